// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and defaults for the ROM/RAM bus controller.
// MEM_BUS_WRITE_VERIFY_EN adds the VERIFY_* readback states.
package mem_bus_pkg;

    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 8;
    localparam int WAIT_DEF = 1;
    localparam int CNT_W    = 4;

    localparam logic TGT_ROM = 1'b0;
    localparam logic TGT_RAM = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_DONE
`ifdef MEM_BUS_WRITE_VERIFY_EN
        ,
        S_VERIFY_TURN,
        S_VERIFY_SETUP,
        S_VERIFY_ACCESS,
        S_VERIFY_HOLD
`endif
    } state_t;

endpackage

// File: rtl/mem_bus_wait_timer.sv
// mem_bus_wait_timer: loadable down-counter for the ACCESS phase.
// tc is high while the count sits at zero.
module mem_bus_wait_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          tc
);

    logic [CW-1:0] cnt;

    // load on entry to the access phase, then count down to zero
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: req/done initiator for async 16x8 ROM/RAM chips.
// Optional RAM write readback: define MEM_BUS_WRITE_VERIFY_EN.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int WAIT_CYCLES = WAIT_DEF
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          req,
    input  logic          we,
    input  logic          tgt,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          err,
    output logic          busy,
    output logic [AW-1:0] bus_addr,
    inout  wire  [DW-1:0] bus_data,
    output logic          rom_ceb,
    output logic          ram_ceb,
    output logic          ram_web,
    output logic          ram_oeb
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_t        state, nstate;
    logic          lat_we, lat_tgt;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          drv;
    logic          e_we, e_tgt;
    logic [AW-1:0] e_addr;
    logic          n_rom_ceb, n_ram_ceb, n_ram_web, n_ram_oeb;
    logic          n_drv, n_err;
    logic [AW-1:0] n_addr;
    logic          tc, tmr_load, tmr_en, rd_cap;

    // request fields as seen this cycle: live in IDLE, latched after
    assign e_we   = (state == S_IDLE) ? we   : lat_we;
    assign e_tgt  = (state == S_IDLE) ? tgt  : lat_tgt;
    assign e_addr = (state == S_IDLE) ? addr : lat_addr;

`ifdef MEM_BUS_WRITE_VERIFY_EN
    assign tmr_load = (state == S_SETUP) || (state == S_VERIFY_SETUP);
    assign tmr_en   = (state == S_ACCESS) || (state == S_VERIFY_ACCESS);
    assign rd_cap   = ((state == S_ACCESS) && !lat_we)
                    || (state == S_VERIFY_ACCESS);
`else
    assign tmr_load = (state == S_SETUP);
    assign tmr_en   = (state == S_ACCESS);
    assign rd_cap   = (state == S_ACCESS) && !lat_we;
`endif

    mem_bus_wait_timer #(
        .CW(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rstb    (rstb),
        .load    (tmr_load),
        .en      (tmr_en),
        .load_val(LOAD_VAL),
        .tc      (tc)
    );

    assign bus_data = drv ? lat_wdata : {DW{1'bz}};

    // next-state and completion status
    always_comb begin
        nstate = state;
        n_err  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    if (tgt == TGT_ROM && we) begin
                        nstate = S_DONE;
                        n_err  = 1'b1;
                    end else begin
                        nstate = S_SETUP;
                    end
                end
            end
            S_SETUP:  nstate = S_ACCESS;
            S_ACCESS: if (tc) nstate = S_HOLD;
`ifdef MEM_BUS_WRITE_VERIFY_EN
            S_HOLD:   nstate = lat_we ? S_VERIFY_TURN : S_DONE;
            S_VERIFY_TURN:   nstate = S_VERIFY_SETUP;
            S_VERIFY_SETUP:  nstate = S_VERIFY_ACCESS;
            S_VERIFY_ACCESS: if (tc) nstate = S_VERIFY_HOLD;
            S_VERIFY_HOLD: begin
                nstate = S_DONE;
                n_err  = (rdata != lat_wdata);
            end
`else
            S_HOLD:   nstate = S_DONE;
`endif
            S_DONE:   nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    // pin values for the state being entered
    always_comb begin
        n_rom_ceb = 1'b1;
        n_ram_ceb = 1'b1;
        n_ram_web = 1'b1;
        n_ram_oeb = 1'b1;
        n_drv     = 1'b0;
        n_addr    = bus_addr;
        unique case (nstate)
            S_SETUP: begin
                n_addr    = e_addr;
                n_rom_ceb = e_tgt;
                n_ram_ceb = !e_tgt;
                n_drv     = e_we;
            end
            S_ACCESS: begin
                n_rom_ceb = e_tgt;
                n_ram_ceb = !e_tgt;
                n_drv     = e_we;
                if (e_we) begin
                    n_ram_web = 1'b0;
                end else if (e_tgt == TGT_RAM) begin
                    n_ram_oeb = 1'b0;
                end
            end
            S_HOLD: begin
                n_rom_ceb = e_tgt;
                n_ram_ceb = !e_tgt;
                n_drv     = e_we;
            end
`ifdef MEM_BUS_WRITE_VERIFY_EN
            S_VERIFY_SETUP: n_ram_ceb = 1'b0;
            S_VERIFY_ACCESS: begin
                n_ram_ceb = 1'b0;
                n_ram_oeb = 1'b0;
            end
            S_VERIFY_HOLD: n_ram_ceb = 1'b0;
`endif
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_IDLE;
        else       state <= nstate;
    end

    // capture the request on acceptance
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lat_we    <= 1'b0;
            lat_tgt   <= TGT_ROM;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == S_IDLE && req) begin
            lat_we    <= we;
            lat_tgt   <= tgt;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

    // registered chip pins and core status
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rom_ceb  <= 1'b1;
            ram_ceb  <= 1'b1;
            ram_web  <= 1'b1;
            ram_oeb  <= 1'b1;
            drv      <= 1'b0;
            bus_addr <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rom_ceb  <= n_rom_ceb;
            ram_ceb  <= n_ram_ceb;
            ram_web  <= n_ram_web;
            ram_oeb  <= n_ram_oeb;
            drv      <= n_drv;
            bus_addr <= n_addr;
            done     <= (nstate == S_DONE);
            err      <= (nstate == S_DONE) && n_err;
            busy     <= (nstate != S_IDLE);
        end
    end

    // read data lands on the last access edge
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)             rdata <= '0;
        else if (rd_cap && tc) rdata <= bus_data;
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: two controllers (WAIT 1 and 4) on ROM/RAM chip models.
// Transaction-level reference model; idle bus is held at 8'hE7 by the chip side.
module tb_mem_bus_ctrl;

    localparam int W0 = 1;
    localparam int W1 = 4;
`ifdef MEM_BUS_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    typedef struct {
        int         inst;
        bit         w;
        bit         t;
        logic [3:0] a;
        logic [7:0] d;
        int         lat;
        bit         err;
        logic [7:0] rd;
        int         web;
        int         oeb;
        int         rce;
        int         mce;
        int         viol;
        bit         busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstb;
    logic [1:0] req, we, tgt;
    logic [3:0] addr  [2];
    logic [7:0] wdata [2];

    wire  [7:0] rdata    [2];
    wire  [3:0] bus_addr [2];
    wire  [7:0] bd_obs   [2];
    wire  [1:0] done, err, busy;
    wire  [1:0] rom_ceb, ram_ceb, ram_web, ram_oeb;

    int n_chk  = 0;
    int n_fail = 0;

    int viol      = 0;
    int web_lo[2] = '{0, 0};
    int oeb_lo[2] = '{0, 0};
    int rce_lo[2] = '{0, 0};
    int mce_lo[2] = '{0, 0};

    logic [7:0] mref    [2][16];
    logic [7:0] last_rd [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [3:0] a);
        logic [7:0] x;
        x = {4'h0, a};
        return 8'h2B + x * 8'h1D;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wire  [7:0] bdata;
        logic [7:0] cram [16];
        logic       chip_en;
        logic [7:0] chip_val;

        mem_bus_ctrl #(
            .AW(4),
            .DW(8),
            .WAIT_CYCLES(g == 0 ? W0 : W1)
        ) u (
            .clk     (clk),
            .rstb    (rstb),
            .req     (req[g]),
            .we      (we[g]),
            .tgt     (tgt[g]),
            .addr    (addr[g]),
            .wdata   (wdata[g]),
            .rdata   (rdata[g]),
            .done    (done[g]),
            .err     (err[g]),
            .busy    (busy[g]),
            .bus_addr(bus_addr[g]),
            .bus_data(bdata),
            .rom_ceb (rom_ceb[g]),
            .ram_ceb (ram_ceb[g]),
            .ram_web (ram_web[g]),
            .ram_oeb (ram_oeb[g])
        );

        always @(posedge ram_web[g])
            if (rstb && !ram_ceb[g]) cram[bus_addr[g]] <= bdata;

        always_comb begin
            chip_en  = 1'b0;
            chip_val = 8'hE7;
            if (!ram_ceb[g] && !ram_oeb[g]) begin
                chip_en  = 1'b1;
                chip_val = cram[bus_addr[g]];
            end else if (!rom_ceb[g]) begin
                chip_en  = 1'b1;
                chip_val = rom_val(bus_addr[g]);
            end else if (ram_ceb[g] && rom_ceb[g]) begin
                chip_en  = 1'b1;
            end
        end

        assign bdata     = chip_en ? chip_val : 8'hzz;
        assign bd_obs[g] = bdata;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!ram_web[i] && !ram_oeb[i]) viol = viol + 1;
            if (!rom_ceb[i] && !ram_ceb[i]) viol = viol + 1;
            if (!ram_web[i] && ram_ceb[i])  viol = viol + 1;
            if (rom_ceb[i] && ram_ceb[i] && bd_obs[i] != 8'hE7)
                viol = viol + 1;
            if (!ram_web[i]) web_lo[i] = web_lo[i] + 1;
            if (!ram_oeb[i]) oeb_lo[i] = oeb_lo[i] + 1;
            if (!rom_ceb[i]) rce_lo[i] = rce_lo[i] + 1;
            if (!ram_ceb[i]) mce_lo[i] = mce_lo[i] + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int i, bit w, bit t, logic [3:0] a,
                                logic [7:0] d, int lat, bit e,
                                logic [7:0] rd, int wb, int ob,
                                int rc, int mc);
        vec_t v;
        v = '{i, w, t, a, d, lat, e, rd, wb, ob, rc, mc, 0, 1'b0};
        return v;
    endfunction

    // spec-level expectation for one transaction
    function automatic vec_t model_exp(int i, bit w, bit t,
                                       logic [3:0] a, logic [7:0] d);
        int wc;
        wc = (i == 0) ? W0 : W1;
        if (w && !t)
            return mk(i, w, t, a, d, 1, 1'b1, last_rd[i], 0, 0, 0, 0);
        if (w && VFY)
            return mk(i, w, t, a, d, 2 * wc + 6, 1'b0, d,
                      wc, wc, 0, 2 * wc + 4);
        if (w)
            return mk(i, w, t, a, d, wc + 3, 1'b0, last_rd[i],
                      wc, 0, 0, wc + 2);
        if (t)
            return mk(i, w, t, a, d, wc + 3, 1'b0, mref[i][a],
                      0, wc, 0, wc + 2);
        return mk(i, w, t, a, d, wc + 3, 1'b0, rom_val(a),
                  0, 0, wc + 2, 0);
    endfunction

    function automatic void model_upd(int i, bit w, bit t,
                                      logic [3:0] a, logic [7:0] d);
        if (w && t) begin
            mref[i][a] = d;
            if (VFY) last_rd[i] = d;
        end else if (!w) begin
            last_rd[i] = t ? mref[i][a] : rom_val(a);
        end
    endfunction

    task automatic do_txn(input int i, input bit w, input bit t,
                          input logic [3:0] a, input logic [7:0] d,
                          output vec_t o);
        int n, sw, so, sr, sm, sv;
        @(negedge clk);
        #1;
        sw = web_lo[i]; so = oeb_lo[i]; sr = rce_lo[i];
        sm = mce_lo[i]; sv = viol;
        req[i] = 1'b1; we[i] = w; tgt[i] = t;
        addr[i] = a; wdata[i] = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
            req[i] = 1'b0;
        end while (!done[i] && n < 64);
        o.inst = i; o.w = w; o.t = t; o.a = a; o.d = d;
        o.lat = done[i] ? n : -1;
        o.err = err[i];
        o.rd  = rdata[i];
        @(posedge clk);
        #1;
        o.busy = busy[i];
        o.web  = web_lo[i] - sw;
        o.oeb  = oeb_lo[i] - so;
        o.rce  = rce_lo[i] - sr;
        o.mce  = mce_lo[i] - sm;
        o.viol = viol - sv;
    endtask

    task automatic cmp(input string nm, input vec_t e, input vec_t o);
        chk({nm, "_lat"},  o.lat,  e.lat);
        chk({nm, "_err"},  o.err,  e.err);
        chk({nm, "_rd"},   o.rd,   e.rd);
        chk({nm, "_web"},  o.web,  e.web);
        chk({nm, "_oeb"},  o.oeb,  e.oeb);
        chk({nm, "_romce"}, o.rce, e.rce);
        chk({nm, "_ramce"}, o.mce, e.mce);
        chk({nm, "_inv"},  o.viol, e.viol);
        chk({nm, "_busy"}, o.busy, e.busy);
    endtask

    task automatic run_rand(input int i, input bit w, input bit t,
                            input logic [3:0] a, input logic [7:0] d,
                            input string nm);
        vec_t e, o;
        e = model_exp(i, w, t, a, d);
        do_txn(i, w, t, a, d, o);
        cmp(nm, e, o);
        model_upd(i, w, t, a, d);
    endtask

    initial begin
        vec_t tbl [8];
        vec_t o;
        int   n, wl, wo, wm;

        wl = VFY ? 8 : 4;
        wo = VFY ? 1 : 0;
        wm = VFY ? 6 : 3;
        tbl[0] = mk(0, 1, 1, 4'h3, 8'hA5, wl, 0, VFY ? 8'hA5 : 8'h00,
                    1, wo, 0, wm);
        tbl[1] = mk(0, 0, 1, 4'h3, 8'h00, 4, 0, 8'hA5, 0, 1, 0, 3);
        tbl[2] = mk(0, 0, 0, 4'h0, 8'h00, 4, 0, 8'h2B, 0, 0, 3, 0);
        tbl[3] = mk(0, 1, 0, 4'h1, 8'hC3, 1, 1, 8'h2B, 0, 0, 0, 0);
        tbl[4] = mk(0, 0, 0, 4'h1, 8'h00, 4, 0, 8'h48, 0, 0, 3, 0);
        tbl[5] = mk(0, 1, 1, 4'hF, 8'h5A, wl, 0, VFY ? 8'h5A : 8'h48,
                    1, wo, 0, wm);
        tbl[6] = mk(0, 0, 1, 4'hF, 8'h00, 4, 0, 8'h5A, 0, 1, 0, 3);
        tbl[7] = mk(0, 0, 1, 4'h3, 8'h00, 4, 0, 8'hA5, 0, 1, 0, 3);

        rstb = 1'b0;
        req  = '0; we = '0; tgt = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; last_rd[i] = '0;
            for (int k = 0; k < 16; k++) mref[i][k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rom_ceb",  rom_ceb[i],  1'b1);
            chk("rst_ram_ceb",  ram_ceb[i],  1'b1);
            chk("rst_ram_web",  ram_web[i],  1'b1);
            chk("rst_ram_oeb",  ram_oeb[i],  1'b1);
            chk("rst_bus_addr", bus_addr[i], 4'h0);
            chk("rst_rdata",    rdata[i],    8'h00);
            chk("rst_done",     done[i],     1'b0);
            chk("rst_err",      err[i],      1'b0);
            chk("rst_busy",     busy[i],     1'b0);
            chk("rst_bus_rel",  bd_obs[i],   8'hE7);
        end
        rstb = 1'b1;

        for (int k = 0; k < 8; k++) begin
            do_txn(tbl[k].inst, tbl[k].w, tbl[k].t, tbl[k].a,
                   tbl[k].d, o);
            cmp($sformatf("vec%0d", k), tbl[k], o);
            model_upd(tbl[k].inst, tbl[k].w, tbl[k].t, tbl[k].a,
                      tbl[k].d);
        end

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++)
                run_rand(i, 1'b1, 1'b1, 4'(k), 8'($urandom), "init_wr");

        for (int k = 0; k < 60; k++)
            run_rand(int'($urandom_range(0, 1)), 1'($urandom),
                     1'($urandom), 4'($urandom), 8'($urandom), "rand");

        // req held high across two requests on the WAIT=4 unit
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; tgt[1] = 1'b1;
        addr[1] = 4'h5; wdata[1] = 8'h3C;
        @(posedge clk);
        #1;
        chk("b2b_accept", busy[1], 1'b1);
        we[1] = 1'b0; wdata[1] = 8'h00;
        n = 0;
        while (!done[1] && n < 64) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        chk("b2b_first_lat", n, VFY ? 2 * W1 + 5 : W1 + 2);
        chk("b2b_first_err", err[1], 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_idle_gap", busy[1], 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_second_accept", busy[1], 1'b1);
        req[1] = 1'b0;
        n = 0;
        while (!done[1] && n < 64) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        chk("b2b_second_lat", n, W1 + 2);
        chk("b2b_second_rd", rdata[1], 8'h3C);
        mref[1][5] = 8'h3C;
        last_rd[1] = 8'h3C;
        @(posedge clk);
        #1;

        // a req pulsed while busy is dropped
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; tgt[1] = 1'b1; addr[1] = 4'h5;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        @(posedge clk);
        #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'h6; wdata[1] = 8'h77;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        n = 0;
        while (!done[1] && n < 64) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        chk("busy_req_done_seen", done[1], 1'b1);
        chk("busy_req_rd", rdata[1], 8'h3C);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_req_not_queued", busy[1], 1'b0);
        run_rand(1, 1'b0, 1'b1, 4'h6, 8'h00, "busy_req_ram6");

        // reset in the middle of a RAM write access
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; tgt[0] = 1'b1;
        addr[0] = 4'h7; wdata[0] = 8'h99;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_web_low", ram_web[0], 1'b0);
        #2;
        rstb = 1'b0;
        #1;
        chk("midrst_web",   ram_web[0],  1'b1);
        chk("midrst_ceb",   ram_ceb[0],  1'b1);
        chk("midrst_busy",  busy[0],     1'b0);
        chk("midrst_done",  done[0],     1'b0);
        chk("midrst_addr",  bus_addr[0], 4'h0);
        chk("midrst_bus",   bd_obs[0],   8'hE7);
        @(negedge clk);
        rstb = 1'b1;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        run_rand(0, 1'b1, 1'b1, 4'h7, 8'h55, "post_rst_wr");
        run_rand(0, 1'b0, 1'b1, 4'h7, 8'h00, "post_rst_rd");

        chk("invariants_total", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
